// File: rtl/count_pkg.sv
// Shared definitions for the lab counter and its downstream sequence monitor.
//   state_t : monitor FSM states (2-bit encoding)
//   CNT_W   : default counter value width
//   CNT_MIN : default first value of the legal ring (value after wrap)
//   CNT_MAX : default last value of the legal ring
package count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam int CNT_W   = 4;
  localparam int CNT_MIN = 1;
  localparam int CNT_MAX = 8;

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD event counter, 00..99, wrapping 99 -> 00 without a flag.
//   clk   in  : rising-edge clock
//   rst   in  : synchronous active-high reset to 00
//   clear in  : synchronous soft clear to 00 (same effect as rst)
//   inc   in  : add one this cycle
//   bcd   out : {tens, units}, registered
module bcd2_inc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] bcd
);

  logic [3:0] units, tens;
  logic [3:0] units_nx, tens_nx;

  assign units = bcd[3:0];
  assign tens  = bcd[7:4];

  always_comb begin
    units_nx = units;
    tens_nx  = tens;
    if (inc) begin
      if (units == 4'd9) begin
        units_nx = 4'd0;
        tens_nx  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        units_nx = units + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) bcd <= 8'h00;
    else              bcd <= {tens_nx, units_nx};
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that a sampled counter walks the MIN..MAX ring, pulses on each
// legal MAX->MIN wrap, keeps a BCD wrap count and latches the first illegal
// step in a sticky error.
//   clk        in  : rising-edge clock
//   rst        in  : synchronous active-high reset
//   cnt_in     in  : counter value under observation
//   cnt_valid  in  : sample cnt_in this cycle
//   clear      in  : synchronous soft clear, identical effect to rst
//   wrap_pulse out : one-cycle pulse after each legal MAX->MIN step
//   wraps_bcd  out : BCD wrap count {tens,units}
//   seq_err    out : sticky illegal-sequence flag
//   err_value  out : offending sample
//   err_prev   out : last legal sample before the error (0 if none)
//   busy       out : FSM is in TRACK
module count_seq_monitor
  import count_pkg::*;
#(
  parameter int W   = CNT_W,
  parameter int MIN = CNT_MIN,
  parameter int MAX = CNT_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt_in,
  input  logic         cnt_valid,
  input  logic         clear,
  output logic         wrap_pulse,
  output logic [7:0]   wraps_bcd,
  output logic         seq_err,
  output logic [W-1:0] err_value,
  output logic [W-1:0] err_prev,
  output logic         busy
);

  localparam logic [W:0] MIN_X = (W+1)'(MIN);
  localparam logic [W:0] MAX_X = (W+1)'(MAX);

  state_t       state, state_nx;
  logic [W-1:0] prev, prev_nx;
  logic         wrap_nx, err_nx, inc;
  logic [W-1:0] ev_nx, ep_nx;
  logic [W:0]   v_x, prev_x, expected;
  logic         soft_rst;

  assign soft_rst = rst || clear;
  assign v_x      = {1'b0, cnt_in};
  assign prev_x   = {1'b0, prev};
  // Extra bit keeps prev+1 from aliasing back into range when MAX is 2**W-1.
  assign expected = (prev_x == MAX_X) ? MIN_X : prev_x + 1'b1;

  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    wrap_nx  = 1'b0;
    inc      = 1'b0;
    err_nx   = seq_err;
    ev_nx    = err_value;
    ep_nx    = err_prev;
    case (state)
      IDLE: if (cnt_valid) begin
        if (v_x >= MIN_X && v_x <= MAX_X) begin
          prev_nx  = cnt_in;
          state_nx = TRACK;
        end else begin
          state_nx = ERROR;
          err_nx   = 1'b1;
          ev_nx    = cnt_in;
          ep_nx    = '0;
        end
      end
      TRACK: if (cnt_valid) begin
        if (v_x == expected) begin
          prev_nx = cnt_in;
          if (prev_x == MAX_X) begin
            wrap_nx = 1'b1;
            inc     = 1'b1;
          end
        end else begin
          // Covers stalls (repeat) and out-of-ring values alike.
          state_nx = ERROR;
          err_nx   = 1'b1;
          ev_nx    = cnt_in;
          ep_nx    = prev;
        end
      end
      ERROR: ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state      <= IDLE;
      prev       <= '0;
      wrap_pulse <= 1'b0;
      seq_err    <= 1'b0;
      err_value  <= '0;
      err_prev   <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      wrap_pulse <= wrap_nx;
      seq_err    <= err_nx;
      err_value  <= ev_nx;
      err_prev   <= ep_nx;
      busy       <= (state_nx == TRACK);
    end
  end

  // Counter clears on the same soft_rst, so a wrap coinciding with rst/clear is dropped.
  bcd2_inc u_wraps (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (inc),
    .bcd   (wraps_bcd)
  );

endmodule

// File: tb/tb_count_seq_monitor.sv
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst, clear, cnt_valid;
  logic [3:0] cnt_in;
  logic       wrap_pulse, seq_err, busy;
  logic [7:0] wraps_bcd;
  logic [3:0] err_value, err_prev;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(.W(4), .MIN(1), .MAX(8)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clear(clear),
    .wrap_pulse(wrap_pulse), .wraps_bcd(wraps_bcd), .seq_err(seq_err),
    .err_value(err_value), .err_prev(err_prev), .busy(busy)
  );

  // One clock with given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic r = 1'b0,
                      input logic c = 1'b0);
    cnt_valid = v; cnt_in = d; rst = r; clear = c;
    @(posedge clk); #1;
    cnt_valid = 1'b0; rst = 1'b0; clear = 1'b0;
  endtask

  // Drives 2..8 then 1: one full ring starting after a sampled 1.
  task automatic ring();
    for (int k = 2; k <= 8; k++) step(1'b1, 4'(k));
    step(1'b1, 4'd1);
  endtask

  task automatic test_reset();
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b1);
    checks++;
    if ({wrap_pulse, wraps_bcd, seq_err, err_value, err_prev, busy} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got wp=%b bcd=%h err=%b ev=%0d ep=%0d busy=%b want all 0",
               wrap_pulse, wraps_bcd, seq_err, err_value, err_prev, busy);
    end
  endtask

  task automatic test_first_wrap();
    for (int k = 1; k <= 8; k++) step(1'b1, 4'(k));
    checks++;
    if (wrap_pulse !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_wrap got wp=%b busy=%b want wp=0 busy=1", wrap_pulse, busy);
    end
    step(1'b1, 4'd1);
    checks++;
    if (wrap_pulse !== 1'b1 || wraps_bcd !== 8'h01 || seq_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_wrap got wp=%b bcd=%h err=%b busy=%b want 1 01 0 1",
               wrap_pulse, wraps_bcd, seq_err, busy);
    end
    step(1'b1, 4'd2);
    checks++;
    if (wrap_pulse !== 1'b0 || wraps_bcd !== 8'h01) begin
      failures++;
      $display("FAIL pulse_width got wp=%b bcd=%h want 0 01", wrap_pulse, wraps_bcd);
    end
    for (int k = 3; k <= 8; k++) step(1'b1, 4'(k));
    step(1'b1, 4'd1);
  endtask

  task automatic test_bcd_carry();
    // Count is 02 here; eight more rings reach 10.
    for (int r = 0; r < 8; r++) ring();
    checks++;
    if (wraps_bcd !== 8'h10) begin
      failures++;
      $display("FAIL bcd_carry got %h want 10", wraps_bcd);
    end
  endtask

  task automatic test_rollover();
    for (int r = 0; r < 89; r++) ring();
    checks++;
    if (wraps_bcd !== 8'h99) begin
      failures++;
      $display("FAIL bcd_99 got %h want 99", wraps_bcd);
    end
    ring();
    checks++;
    if (wraps_bcd !== 8'h00 || seq_err !== 1'b0 || wrap_pulse !== 1'b1) begin
      failures++;
      $display("FAIL bcd_rollover got bcd=%h err=%b wp=%b want 00 0 1",
               wraps_bcd, seq_err, wrap_pulse);
    end
  endtask

  task automatic test_error_latch();
    step(1'b1, 4'd2);
    step(1'b1, 4'd3);
    step(1'b1, 4'd5);
    checks++;
    if (seq_err !== 1'b1 || err_value !== 4'd5 || err_prev !== 4'd3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL skip_error got err=%b ev=%0d ep=%0d busy=%b want 1 5 3 0",
               seq_err, err_value, err_prev, busy);
    end
    step(1'b1, 4'd4);
    step(1'b1, 4'd5);
    checks++;
    if (seq_err !== 1'b1 || err_value !== 4'd5 || err_prev !== 4'd3 || busy !== 1'b0
        || wraps_bcd !== 8'h00) begin
      failures++;
      $display("FAIL error_sticky got err=%b ev=%0d ep=%0d busy=%b bcd=%h want 1 5 3 0 00",
               seq_err, err_value, err_prev, busy, wraps_bcd);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    checks++;
    if ({wrap_pulse, wraps_bcd, seq_err, err_value, err_prev, busy} !== 19'd0) begin
      failures++;
      $display("FAIL clear_outputs got err=%b ev=%0d ep=%0d busy=%b bcd=%h want all 0",
               seq_err, err_value, err_prev, busy, wraps_bcd);
    end
    // FSM back in IDLE: a legal first sample starts tracking again.
    step(1'b1, 4'd6);
    checks++;
    if (busy !== 1'b1 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL clear_to_idle got busy=%b err=%b want 1 0", busy, seq_err);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_idle_error();
    step(1'b1, 4'd0);
    checks++;
    if (seq_err !== 1'b1 || err_value !== 4'd0 || err_prev !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_zero got err=%b ev=%0d ep=%0d busy=%b want 1 0 0 0",
               seq_err, err_value, err_prev, busy);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd9);
    checks++;
    if (seq_err !== 1'b1 || err_value !== 4'd9 || err_prev !== 4'd0) begin
      failures++;
      $display("FAIL idle_nine got err=%b ev=%0d ep=%0d want 1 9 0", seq_err, err_value, err_prev);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_rst_clear_wrap();
    for (int k = 1; k <= 8; k++) step(1'b1, 4'(k));
    step(1'b1, 4'd1, 1'b1, 1'b0);
    checks++;
    if (wrap_pulse !== 1'b0 || wraps_bcd !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_on_wrap got wp=%b bcd=%h busy=%b want 0 00 0", wrap_pulse, wraps_bcd, busy);
    end
    for (int k = 1; k <= 8; k++) step(1'b1, 4'(k));
    step(1'b1, 4'd1, 1'b0, 1'b1);
    checks++;
    if (wrap_pulse !== 1'b0 || wraps_bcd !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_on_wrap got wp=%b bcd=%h busy=%b want 0 00 0", wrap_pulse, wraps_bcd, busy);
    end
  endtask

  task automatic test_gaps();
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    step(1'b0, 4'd7);
    step(1'b0, 4'd2);
    for (int k = 3; k <= 8; k++) step(1'b1, 4'(k));
    step(1'b0, 4'd1);
    step(1'b1, 4'd1);
    checks++;
    if (wrap_pulse !== 1'b1 || wraps_bcd !== 8'h01 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL gap_wrap got wp=%b bcd=%h err=%b want 1 01 0", wrap_pulse, wraps_bcd, seq_err);
    end
    step(1'b0, 4'd1);
    checks++;
    if (wrap_pulse !== 1'b0 || wraps_bcd !== 8'h01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL gap_pulse_drop got wp=%b bcd=%h busy=%b want 0 01 1", wrap_pulse, wraps_bcd, busy);
    end
  endtask

  task automatic test_back_to_back();
    // Stall: same value twice is illegal.
    step(1'b1, 4'd2);
    step(1'b1, 4'd2);
    checks++;
    if (seq_err !== 1'b1 || err_value !== 4'd2 || err_prev !== 4'd2) begin
      failures++;
      $display("FAIL stall_error got err=%b ev=%0d ep=%0d want 1 2 2", seq_err, err_value, err_prev);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    // MAX followed by MAX+1 is out of ring, not a wrap.
    for (int k = 1; k <= 8; k++) step(1'b1, 4'(k));
    step(1'b1, 4'd9);
    checks++;
    if (seq_err !== 1'b1 || err_value !== 4'd9 || err_prev !== 4'd8 || wrap_pulse !== 1'b0
        || wraps_bcd !== 8'h00) begin
      failures++;
      $display("FAIL max_plus_one got err=%b ev=%0d ep=%0d wp=%b bcd=%h want 1 9 8 0 00",
               seq_err, err_value, err_prev, wrap_pulse, wraps_bcd);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; cnt_valid = 1'b0; cnt_in = '0;
    test_reset();
    test_first_wrap();
    test_bcd_carry();
    test_rollover();
    test_error_latch();
    test_idle_error();
    test_rst_clear_wrap();
    test_gaps();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
